// File: rtl/pipe_reg_pkg.sv
// Shared processor pipeline definitions: NOP encoding, inter-stage boundary widths
// and the per-edge command decode used by the latch chain.
package pipe_reg_pkg;

  // Canonical no-op instruction (addi x0, x0, 0)
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } fd_t;

  localparam int FD_W = $bits(fd_t);
  localparam int DX_W = 160;
  localparam int XM_W = 112;
  localparam int MW_W = 72;

  typedef enum logic [1:0] {
    CMD_SHIFT = 2'd0,
    CMD_STALL = 2'd1,
    CMD_FLUSH = 2'd2
  } stage_cmd_e;

  // Flush outranks stall, stall outranks shift.
  function automatic stage_cmd_e decode_cmd(input logic flush, input logic stall);
    if (flush) return CMD_FLUSH;
    if (stall) return CMD_STALL;
    return CMD_SHIFT;
  endfunction

endpackage

// File: rtl/pipe_reg_if.sv
// Hazard-unit/upstream facing bundle of the pipeline latch chain.
// master = upstream stage + hazard unit, slave = the latch chain.
interface pipe_reg_if #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 1
);
  logic                         stall;
  logic                         flush;
  logic                         valid_in;
  logic [WIDTH-1:0]             data_in;
  logic                         valid_out;
  logic [WIDTH-1:0]             data_out;
  logic [$clog2(STAGES+1)-1:0]  occupancy;

  modport master (
    output stall, flush, valid_in, data_in,
    input  valid_out, data_out, occupancy
  );

  modport slave (
    input  stall, flush, valid_in, data_in,
    output valid_out, data_out, occupancy
  );
endinterface

// File: rtl/pipe_stage.sv
// One pipeline latch: WIDTH payload bits plus valid, async clear, hold and NOP load.
// Latency: 1 cycle.
// Backpressure: none generated; hold freezes the stage, load_nop turns it into a bubble.
module pipe_stage #(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             hold,
  input  logic             load_nop,
  input  logic             valid_d,
  input  logic [WIDTH-1:0] data_d,
  output logic             valid_q,
  output logic [WIDTH-1:0] data_q
);

  // A slot without a valid bit always carries NOP_VALUE, whatever arrives on data_d.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      valid_q <= 1'b0;
      data_q  <= NOP_VALUE;
    end else if (load_nop) begin
      valid_q <= 1'b0;
      data_q  <= NOP_VALUE;
    end else if (!hold) begin
      valid_q <= valid_d;
      data_q  <= valid_d ? data_d : NOP_VALUE;
    end
  end

endmodule

// File: rtl/pipe_reg.sv
// Multi-stage pipeline boundary latch with stall, flush and a valid-entry count.
// Latency: STAGES cycles data_in to data_out, plus one per stall cycle.
// Backpressure: none generated; stall/flush come from the hazard unit.
module pipe_reg
  import pipe_reg_pkg::*;
#(
  parameter int               WIDTH     = 64,
  parameter int               STAGES    = 1,
  parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{1'b0}}
) (
  input  logic       clk,
  input  logic       clr,
  pipe_reg_if.slave  bus
);

  localparam int OCC_W = $clog2(STAGES + 1);
  localparam logic [OCC_W:0] OCC_MAX = STAGES[OCC_W:0];

  stage_cmd_e        cmd;
  logic              hold;
  logic              load_nop;
  logic              v [STAGES];
  logic [WIDTH-1:0]  p [STAGES];

  assign cmd      = decode_cmd(bus.flush, bus.stall);
  assign hold     = (cmd == CMD_STALL);
  assign load_nop = (cmd == CMD_FLUSH);

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             vd;
    logic [WIDTH-1:0] pd;

    if (k == 0) begin : g_head
      assign vd = bus.valid_in;
      assign pd = bus.data_in;
    end else begin : g_body
      assign vd = v[k-1];
      assign pd = p[k-1];
    end

    pipe_stage #(
      .WIDTH     (WIDTH),
      .NOP_VALUE (NOP_VALUE)
    ) u_stage (
      .clk      (clk),
      .clr      (clr),
      .hold     (hold),
      .load_nop (load_nop),
      .valid_d  (vd),
      .data_d   (pd),
      .valid_q  (v[k]),
      .data_q   (p[k])
    );
  end

  logic [OCC_W-1:0] occ_q;
  logic [OCC_W:0]   occ_sum;
  logic [OCC_W-1:0] occ_shift;

  // One extra bit so a wrap in either direction is visible before truncation.
  assign occ_sum = {1'b0, occ_q}
                 + {{OCC_W{1'b0}}, bus.valid_in}
                 - {{OCC_W{1'b0}}, v[STAGES-1]};

  always_comb begin
    occ_shift = occ_sum[OCC_W-1:0];
    // Unreachable while the count tracks the valid bits; keeps it in range regardless.
    if (occ_sum > OCC_MAX) occ_shift = occ_q;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      occ_q <= '0;
    end else begin
      case (cmd)
        CMD_FLUSH: occ_q <= '0;
        CMD_SHIFT: occ_q <= occ_shift;
        default:   occ_q <= occ_q;
      endcase
    end
  end

  assign bus.valid_out = v[STAGES-1];
  assign bus.data_out  = p[STAGES-1];
  assign bus.occupancy = occ_q;

endmodule

// File: tb/tb_pipe_reg.sv
// Scoreboard bench for pipe_reg at depths 3, 2 and 1.
module tb_pipe_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr_a, clr_b, clr_c;

  pipe_reg_if #(.WIDTH(64), .STAGES(3)) a_if();
  pipe_reg_if #(.WIDTH(16), .STAGES(2)) b_if();
  pipe_reg_if #(.WIDTH(8),  .STAGES(1)) c_if();

  pipe_reg #(.WIDTH(64), .STAGES(3), .NOP_VALUE(64'h0))   u_a (.clk(clk), .clr(clr_a), .bus(a_if));
  pipe_reg #(.WIDTH(16), .STAGES(2), .NOP_VALUE(16'hDEAD)) u_b (.clk(clk), .clr(clr_b), .bus(b_if));
  pipe_reg #(.WIDTH(8),  .STAGES(1), .NOP_VALUE(8'hA5))   u_c (.clk(clk), .clr(clr_c), .bus(c_if));

  typedef struct {
    logic        v;
    logic [63:0] p;
    logic [31:0] occ;
  } exp_t;

  exp_t sbq[$];
  int compared   = 0;
  int mismatched = 0;

  logic        mv [3][3];
  logic [63:0] mp [3][3];
  int          ns    [3] = '{3, 2, 1};
  logic [63:0] nop   [3] = '{64'h0, 64'hDEAD, 64'hA5};
  logic [63:0] wmask [3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF, 64'hFF};

  function automatic logic obs_v(input int d);
    case (d)
      0: return a_if.valid_out;
      1: return b_if.valid_out;
      default: return c_if.valid_out;
    endcase
  endfunction

  function automatic logic [63:0] obs_p(input int d);
    case (d)
      0: return a_if.data_out;
      1: return {48'h0, b_if.data_out};
      default: return {56'h0, c_if.data_out};
    endcase
  endfunction

  function automatic logic [31:0] obs_o(input int d);
    case (d)
      0: return {30'h0, a_if.occupancy};
      1: return {30'h0, b_if.occupancy};
      default: return {31'h0, c_if.occupancy};
    endcase
  endfunction

  task automatic model_clear(input int d);
    for (int k = 0; k < 3; k++) begin
      mv[d][k] = 1'b0;
      mp[d][k] = nop[d];
    end
  endtask

  // Drive one cycle, advance the reference model, queue the expected outputs.
  task automatic drive_cycle(input int d, input logic st, input logic fl,
                             input logic vi, input logic [63:0] di);
    exp_t e;
    int cnt;
    case (d)
      0: begin a_if.stall = st; a_if.flush = fl; a_if.valid_in = vi; a_if.data_in = di; end
      1: begin b_if.stall = st; b_if.flush = fl; b_if.valid_in = vi; b_if.data_in = di[15:0]; end
      default: begin c_if.stall = st; c_if.flush = fl; c_if.valid_in = vi; c_if.data_in = di[7:0]; end
    endcase
    if (fl) begin
      model_clear(d);
    end else if (!st) begin
      for (int k = ns[d] - 1; k > 0; k--) begin
        mv[d][k] = mv[d][k-1];
        mp[d][k] = mp[d][k-1];
      end
      mv[d][0] = vi;
      mp[d][0] = vi ? (di & wmask[d]) : nop[d];
    end
    cnt = 0;
    for (int k = 0; k < ns[d]; k++) if (mv[d][k]) cnt++;
    e.v   = mv[d][ns[d]-1];
    e.p   = mp[d][ns[d]-1];
    e.occ = cnt;
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    exp_t e;
    #2;
    compared++;
    if (a_if.valid_out !== 1'b0 || a_if.data_out !== 64'h0 || a_if.occupancy !== 2'd0) begin
      mismatched++;
      $display("FAIL reset_a: got v=%b d=%h occ=%0d, want v=0 d=0 occ=0", a_if.valid_out, a_if.data_out, a_if.occupancy);
    end
    compared++;
    if (b_if.valid_out !== 1'b0 || b_if.data_out !== 16'hDEAD || b_if.occupancy !== 2'd0) begin
      mismatched++;
      $display("FAIL reset_b: got v=%b d=%h occ=%0d, want v=0 d=dead occ=0", b_if.valid_out, b_if.data_out, b_if.occupancy);
    end
    compared++;
    if (c_if.valid_out !== 1'b0 || c_if.data_out !== 8'hA5 || c_if.occupancy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_c: got v=%b d=%h occ=%0d, want v=0 d=a5 occ=0", c_if.valid_out, c_if.data_out, c_if.occupancy);
    end
    for (int d = 0; d < 3; d++) model_clear(d);
    @(posedge clk);
    #1;
    clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;

    for (int i = 1; i <= 3; i++) begin
      drive_cycle(0, 1'b0, 1'b0, 1'b1, 64'(i));
      e = sbq.pop_front();
      compared++;
      if (obs_v(0) !== e.v || obs_p(0) !== e.p || obs_o(0) !== e.occ) begin
        mismatched++;
        $display("FAIL reset_prefill[%0d]: got v=%b d=%h occ=%0d, want v=%b d=%h occ=%0d",
                 i, obs_v(0), obs_p(0), obs_o(0), e.v, e.p, e.occ);
      end
    end

    // Clear mid-stream while a stall is also asserted: must act before any edge.
    a_if.stall = 1'b1; a_if.valid_in = 1'b1; a_if.data_in = 64'h99;
    #2;
    clr_a = 1'b1;
    #1;
    compared++;
    if (a_if.valid_out !== 1'b0 || a_if.data_out !== 64'h0 || a_if.occupancy !== 2'd0) begin
      mismatched++;
      $display("FAIL reset_async: got v=%b d=%h occ=%0d, want v=0 d=0 occ=0", a_if.valid_out, a_if.data_out, a_if.occupancy);
    end
    model_clear(0);
    a_if.stall = 1'b0;
    @(posedge clk);
    #1;
    compared++;
    if (a_if.valid_out !== 1'b0 || a_if.data_out !== 64'h0 || a_if.occupancy !== 2'd0) begin
      mismatched++;
      $display("FAIL reset_held: got v=%b d=%h occ=%0d, want v=0 d=0 occ=0", a_if.valid_out, a_if.data_out, a_if.occupancy);
    end
    clr_a = 1'b0;

    drive_cycle(0, 1'b0, 1'b0, 1'b1, 64'h77);
    e = sbq.pop_front();
    compared++;
    if (obs_v(0) !== e.v || obs_p(0) !== e.p || obs_o(0) !== e.occ) begin
      mismatched++;
      $display("FAIL reset_first_sb: got v=%b d=%h occ=%0d, want v=%b d=%h occ=%0d",
               obs_v(0), obs_p(0), obs_o(0), e.v, e.p, e.occ);
    end
    compared++;
    if (a_if.occupancy !== 2'd1 || a_if.valid_out !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_first_capture: got occ=%0d v=%b, want occ=1 v=0", a_if.occupancy, a_if.valid_out);
    end
  endtask

  task automatic test_fill;
    exp_t e;
    logic [63:0] dat;
    drive_cycle(0, 1'b0, 1'b1, 1'b0, 64'h0);
    e = sbq.pop_front();
    compared++;
    if (obs_v(0) !== e.v || obs_p(0) !== e.p || obs_o(0) !== e.occ) begin
      mismatched++;
      $display("FAIL fill_flush: got v=%b d=%h occ=%0d, want v=%b d=%h occ=%0d",
               obs_v(0), obs_p(0), obs_o(0), e.v, e.p, e.occ);
    end
    for (int i = 0; i < 3; i++) begin
      dat = 64'h11 * 64'(i + 1);
      drive_cycle(0, 1'b0, 1'b0, 1'b1, dat);
      e = sbq.pop_front();
      compared++;
      if (obs_v(0) !== e.v || obs_p(0) !== e.p || obs_o(0) !== e.occ) begin
        mismatched++;
        $display("FAIL fill_sb[%0d]: got v=%b d=%h occ=%0d, want v=%b d=%h occ=%0d",
                 i, obs_v(0), obs_p(0), obs_o(0), e.v, e.p, e.occ);
      end
      compared++;
      if (obs_o(0) !== 32'(i + 1)) begin
        mismatched++;
        $display("FAIL fill_occ[%0d]: got %0d, want %0d", i, obs_o(0), i + 1);
      end
    end
    compared++;
    if (a_if.data_out !== 64'h11 || a_if.valid_out !== 1'b1) begin
      mismatched++;
      $display("FAIL fill_latency: got v=%b d=%h, want v=1 d=11", a_if.valid_out, a_if.data_out);
    end
  endtask

  task automatic test_stall;
    exp_t e;
    logic [63:0] after [3] = '{64'h22, 64'h33, 64'h0};
    for (int i = 0; i < 2; i++) begin
      drive_cycle(0, 1'b1, 1'b0, 1'b1, 64'h44);
      e = sbq.pop_front();
      compared++;
      if (obs_v(0) !== e.v || obs_p(0) !== e.p || obs_o(0) !== e.occ) begin
        mismatched++;
        $display("FAIL stall_sb[%0d]: got v=%b d=%h occ=%0d, want v=%b d=%h occ=%0d",
                 i, obs_v(0), obs_p(0), obs_o(0), e.v, e.p, e.occ);
      end
      compared++;
      if (a_if.data_out !== 64'h11 || a_if.occupancy !== 2'd3) begin
        mismatched++;
        $display("FAIL stall_hold[%0d]: got d=%h occ=%0d, want d=11 occ=3", i, a_if.data_out, a_if.occupancy);
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(0, 1'b0, 1'b0, 1'b0, 64'h0);
      e = sbq.pop_front();
      compared++;
      if (obs_v(0) !== e.v || obs_p(0) !== e.p || obs_o(0) !== e.occ) begin
        mismatched++;
        $display("FAIL stall_drain_sb[%0d]: got v=%b d=%h occ=%0d, want v=%b d=%h occ=%0d",
                 i, obs_v(0), obs_p(0), obs_o(0), e.v, e.p, e.occ);
      end
      compared++;
      if (a_if.data_out !== after[i]) begin
        mismatched++;
        $display("FAIL stall_drain[%0d]: got d=%h, want d=%h", i, a_if.data_out, after[i]);
      end
    end
  endtask

  task automatic test_flush_priority;
    exp_t e;
    drive_cycle(0, 1'b0, 1'b0, 1'b1, 64'hA1);
    e = sbq.pop_front();
    drive_cycle(0, 1'b0, 1'b0, 1'b1, 64'hA2);
    e = sbq.pop_front();
    compared++;
    if (obs_o(0) !== e.occ) begin
      mismatched++;
      $display("FAIL flush_prefill: got occ=%0d, want occ=%0d", obs_o(0), e.occ);
    end
    drive_cycle(0, 1'b1, 1'b1, 1'b1, 64'h55);
    e = sbq.pop_front();
    compared++;
    if (obs_v(0) !== e.v || obs_p(0) !== e.p || obs_o(0) !== e.occ) begin
      mismatched++;
      $display("FAIL flush_sb: got v=%b d=%h occ=%0d, want v=%b d=%h occ=%0d",
               obs_v(0), obs_p(0), obs_o(0), e.v, e.p, e.occ);
    end
    compared++;
    if (a_if.valid_out !== 1'b0 || a_if.data_out !== 64'h0 || a_if.occupancy !== 2'd0) begin
      mismatched++;
      $display("FAIL flush_wins: got v=%b d=%h occ=%0d, want v=0 d=0 occ=0", a_if.valid_out, a_if.data_out, a_if.occupancy);
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(0, 1'b0, 1'b0, 1'b0, 64'h0);
      e = sbq.pop_front();
      compared++;
      if (obs_v(0) !== e.v || obs_p(0) !== e.p || obs_o(0) !== e.occ || a_if.data_out === 64'h55) begin
        mismatched++;
        $display("FAIL flush_drain[%0d]: got v=%b d=%h occ=%0d, want v=%b d=%h occ=%0d",
                 i, obs_v(0), obs_p(0), obs_o(0), e.v, e.p, e.occ);
      end
    end
  endtask

  task automatic test_bubbles;
    exp_t e;
    logic        vin  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [63:0] din  [5] = '{64'hA, 64'hB, 64'hC, 64'h0, 64'h0};
    logic [15:0] want_d [5] = '{16'hDEAD, 16'h000A, 16'hDEAD, 16'h000C, 16'hDEAD};
    logic        want_v [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1, 1'b0, 1'b0, vin[i], din[i]);
      e = sbq.pop_front();
      compared++;
      if (obs_v(1) !== e.v || obs_p(1) !== e.p || obs_o(1) !== e.occ) begin
        mismatched++;
        $display("FAIL bubble_sb[%0d]: got v=%b d=%h occ=%0d, want v=%b d=%h occ=%0d",
                 i, obs_v(1), obs_p(1), obs_o(1), e.v, e.p, e.occ);
      end
      compared++;
      if (b_if.data_out !== want_d[i] || b_if.valid_out !== want_v[i] || b_if.occupancy > 2'd2) begin
        mismatched++;
        $display("FAIL bubble_seq[%0d]: got v=%b d=%h occ=%0d, want v=%b d=%h occ<=2",
                 i, b_if.valid_out, b_if.data_out, b_if.occupancy, want_v[i], want_d[i]);
      end
    end
  endtask

  task automatic test_degenerate;
    exp_t e;
    logic st, fl, vi;
    logic [63:0] di;
    for (int i = 0; i < 1000; i++) begin
      fl = ($urandom_range(0, 7) == 0);
      st = ($urandom_range(0, 3) == 0);
      vi = $urandom_range(0, 1) == 1;
      di = 64'($urandom_range(0, 255));
      drive_cycle(2, st, fl, vi, di);
      e = sbq.pop_front();
      compared++;
      if (obs_v(2) !== e.v || obs_p(2) !== e.p || obs_o(2) !== e.occ) begin
        mismatched++;
        $display("FAIL degenerate[%0d]: got v=%b d=%h occ=%0d, want v=%b d=%h occ=%0d",
                 i, obs_v(2), obs_p(2), obs_o(2), e.v, e.p, e.occ);
      end
    end
  endtask

  initial begin
    clr_a = 1'b1; clr_b = 1'b1; clr_c = 1'b1;
    a_if.stall = 1'b0; a_if.flush = 1'b0; a_if.valid_in = 1'b0; a_if.data_in = '0;
    b_if.stall = 1'b0; b_if.flush = 1'b0; b_if.valid_in = 1'b0; b_if.data_in = '0;
    c_if.stall = 1'b0; c_if.flush = 1'b0; c_if.valid_in = 1'b0; c_if.data_in = '0;
    test_reset();
    test_fill();
    test_stall();
    test_flush_priority();
    test_bubbles();
    test_degenerate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
